// File: rtl/reg_operand_fetch_pkg.sv
// reg_operand_fetch_pkg: register-file geometry shared by decode, reg file and operand fetch
package reg_operand_fetch_pkg;
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_NUMREGS     = 32;
  localparam int DEF_LOG2NUMREGS = 5;
  localparam int REG_ZERO        = 0;
endpackage

// File: rtl/reg_operand_fetch_scoreboard.sv
// rof_scoreboard: pending-write bit per register for long-latency producers
module rof_scoreboard
  import reg_operand_fetch_pkg::*;
#(
  parameter int NUMREGS     = DEF_NUMREGS,
  parameter int LOG2NUMREGS = DEF_LOG2NUMREGS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [LOG2NUMREGS-1:0] set_idx,
  input  logic                   clr_en,
  input  logic [LOG2NUMREGS-1:0] clr_idx,
  input  logic [LOG2NUMREGS-1:0] a_idx,
  input  logic [LOG2NUMREGS-1:0] b_idx,
  output logic                   a_pend,
  output logic                   b_pend
);
  logic [NUMREGS-1:0] pend, set_mask, clr_mask;
  always_comb begin
    set_mask = set_en ? NUMREGS'(1) << set_idx : '0;
    clr_mask = clr_en ? NUMREGS'(1) << clr_idx : '0;
  end
  // set is OR-ed after the clear so a same-cycle set of the same index wins
  always_ff @(posedge clk or posedge reset)
    if (reset) pend <= '0;
    else pend <= (pend & ~clr_mask) | set_mask;
  assign a_pend = pend[a_idx];
  assign b_pend = pend[b_idx];
endmodule

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: R/O operand-fetch stage with writeback forwarding and RAW-hazard stalls
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUMREGS     = DEF_NUMREGS,
  parameter int LOG2NUMREGS = DEF_LOG2NUMREGS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LOG2NUMREGS-1:0] in_rs,
  input  logic [LOG2NUMREGS-1:0] in_rt,
  input  logic                   in_a_use,
  input  logic                   in_b_use,
  input  logic [LOG2NUMREGS-1:0] in_rd,
  input  logic                   in_wr,
  input  logic                   in_long,
  output logic [LOG2NUMREGS-1:0] rf_a_reg,
  output logic [LOG2NUMREGS-1:0] rf_b_reg,
  output logic                   rf_a_en,
  output logic                   rf_b_en,
  input  logic [WIDTH-1:0]       rf_a_data,
  input  logic [WIDTH-1:0]       rf_b_data,
  input  logic                   wb_we,
  input  logic [LOG2NUMREGS-1:0] wb_reg,
  input  logic [WIDTH-1:0]       wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic [LOG2NUMREGS-1:0] out_rd,
  output logic                   out_wr
);
  localparam logic [LOG2NUMREGS-1:0] ZERO = LOG2NUMREGS'(REG_ZERO);
  logic                   w, accept, hazard, r_adv, a_pend, b_pend, clr_a, clr_b;
  logic                   r_valid, r_wr, byp_a, byp_b;
  logic [LOG2NUMREGS-1:0] r_rs, r_rt, r_rd, o_rs, o_rt;
  logic [WIDTH-1:0]       byp_da, byp_db, r_a, r_b, ld_a, ld_b;
  assign w        = wb_we & (wb_reg != ZERO);
  assign clr_a    = w & (wb_reg == in_rs);
  assign clr_b    = w & (wb_reg == in_rt);
  assign hazard   = (in_a_use & a_pend & ~clr_a) | (in_b_use & b_pend & ~clr_b);
  assign r_adv    = r_valid & (~out_valid | out_ready);
  assign in_ready = ~flush & ~hazard & (~r_valid | r_adv);
  assign accept   = in_valid & in_ready;
  assign rf_a_reg = in_rs;
  assign rf_b_reg = in_rt;
  assign rf_a_en  = accept;
  assign rf_b_en  = accept;
  rof_scoreboard #(.NUMREGS(NUMREGS), .LOG2NUMREGS(LOG2NUMREGS)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept & in_wr & in_long & (in_rd != ZERO)),
    .set_idx (in_rd),
    .clr_en  (w),
    .clr_idx (wb_reg),
    .a_idx   (in_rs),
    .b_idx   (in_rt),
    .a_pend  (a_pend),
    .b_pend  (b_pend)
  );
  // RAM q is stale for writes on or after the read edge; bypass regs and the late W patch cover that
  always_comb begin
    r_a  = (r_rs == ZERO) ? '0 : byp_a ? byp_da : rf_a_data;
    r_b  = (r_rt == ZERO) ? '0 : byp_b ? byp_db : rf_b_data;
    ld_a = (w && wb_reg == r_rs) ? wb_data : r_a;
    ld_b = (w && wb_reg == r_rt) ? wb_data : r_b;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_wr      <= 1'b0;
      byp_a     <= 1'b0;
      byp_b     <= 1'b0;
      byp_da    <= '0;
      byp_db    <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
      o_rs      <= '0;
      o_rt      <= '0;
    end else begin
      r_valid   <= ~flush & (accept | (r_valid & ~r_adv));
      out_valid <= ~flush & (r_adv | (out_valid & ~out_ready));
      if (accept) begin
        r_rs   <= in_rs;
        r_rt   <= in_rt;
        r_rd   <= in_rd;
        r_wr   <= in_wr;
        byp_a  <= clr_a;
        byp_b  <= clr_b;
        byp_da <= wb_data;
        byp_db <= wb_data;
      end else if (r_valid & ~r_adv) begin
        if (w && wb_reg == r_rs) begin
          byp_a  <= 1'b1;
          byp_da <= wb_data;
        end
        if (w && wb_reg == r_rt) begin
          byp_b  <= 1'b1;
          byp_db <= wb_data;
        end
      end
      if (r_adv) begin
        out_a  <= ld_a;
        out_b  <= ld_b;
        out_rd <= r_rd;
        out_wr <= r_wr;
        o_rs   <= r_rs;
        o_rt   <= r_rt;
      end else if (out_valid & ~out_ready) begin
        if (w && wb_reg == o_rs) out_a <= wb_data;
        if (w && wb_reg == o_rt) out_b <= wb_data;
      end
    end
endmodule
